// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types for the I2C command sequencer
package i2c_pkg;

    localparam int I2C_CMD_W = 24;

    typedef struct packed {
        logic       wr_rd;
        logic [6:0] chip_addr;
        logic [7:0] reg_addr;
        logic [7:0] tx_data;
    } i2c_cmd_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        REQ  = 3'd2,
        ACK  = 3'd3,
        REL  = 3'd4,
        DONE = 3'd5
    } seq_state_t;

endpackage

// File: rtl/i2c_cmd_ram.sv
// rtl/i2c_cmd_ram.sv - command table storage, one write port and one registered read port
module i2c_cmd_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 24,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/i2c_cmd_seq_sv.sv
// rtl/i2c_cmd_seq_sv.sv - replays a table of I2C transactions over the master req/ack handshake
// Optional ack/release watchdog: I2C_SEQ_TIMEOUT_EN
module i2c_cmd_seq_sv
    import i2c_pkg::*;
#(
    parameter int DEPTH   = 16,
`ifdef I2C_SEQ_TIMEOUT_EN
    parameter int TMO_CYC = 1 << 20,
`endif
    parameter int COMP    = 250,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [23:0]   cmd_wdata,
    input  logic [AW:0]   cmd_cnt,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] cur_idx,
    input  logic [AW-1:0] rb_addr,
    output logic [7:0]    rb_data,
`ifdef I2C_SEQ_TIMEOUT_EN
    output logic          timeout,
`endif
    output logic          m_tr_en,
    output logic [9:0]    m_comp,
    output logic [6:0]    m_chip_addr,
    output logic [7:0]    m_reg_addr,
    output logic [7:0]    m_tx_data,
    output logic          m_wr_rd,
    output logic          m_tx_rx_req,
    input  logic          m_tx_rx_req_ack,
    input  logic [7:0]    m_rx_data
);

    localparam int          CW      = AW + 1;
    localparam logic [AW:0] CNT_MAX = CW'(DEPTH);
    localparam logic [AW:0] CNT_ONE = CW'(1);

    seq_state_t              state, state_d;
    logic [AW-1:0]           idx, idx_d;
    logic [AW:0]             cnt_q, cnt_d, cnt_clamp;
    logic                    load_cmd;
    logic                    rb_we;
    i2c_cmd_t                cur_cmd;
    logic [I2C_CMD_W-1:0]    ram_rdata;
    logic [7:0]              rb [DEPTH];

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam logic [20:0] TMO_LAST = 21'(TMO_CYC - 1);
    logic [20:0] tmo_cnt;
    logic        timeout_set;
    logic        timeout_clr;
`endif

    assign cnt_clamp = (cmd_cnt > CNT_MAX) ? CNT_MAX : cmd_cnt;

    // Read address follows the next index so the entry is ready by the end of LOAD.
    i2c_cmd_ram #(
        .DEPTH(DEPTH),
        .W    (I2C_CMD_W)
    ) u_ram (
        .clk  (clk),
        .we   (cmd_we && (state == IDLE)),
        .waddr(cmd_addr),
        .wdata(cmd_wdata),
        .raddr(idx_d),
        .rdata(ram_rdata)
    );

    always_comb begin
        state_d  = state;
        idx_d    = idx;
        cnt_d    = cnt_q;
        load_cmd = 1'b0;
        rb_we    = 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
        timeout_set = 1'b0;
        timeout_clr = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    cnt_d   = cnt_clamp;
                    idx_d   = '0;
                    state_d = (cnt_clamp == '0) ? DONE : LOAD;
`ifdef I2C_SEQ_TIMEOUT_EN
                    timeout_clr = 1'b1;
`endif
                end
            end
            LOAD: begin
                load_cmd = 1'b1;
                state_d  = REQ;
            end
            REQ: state_d = ACK;
            ACK: begin
                if (m_tx_rx_req_ack) begin
                    rb_we   = !cur_cmd.wr_rd;
                    state_d = REL;
                end
            end
            REL: begin
                if (!m_tx_rx_req_ack) begin
                    if ({1'b0, idx} == cnt_q - CNT_ONE) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx + AW'(1);
                        state_d = LOAD;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef I2C_SEQ_TIMEOUT_EN
        if (((state == ACK) || (state == REL)) && (state_d == state) && (tmo_cnt == TMO_LAST)) begin
            state_d     = DONE;
            timeout_set = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            cnt_q   <= '0;
            cur_cmd <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            cnt_q <= cnt_d;
            if (load_cmd) begin
                cur_cmd <= i2c_cmd_t'(ram_rdata);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rb_we) begin
            rb[idx] <= m_rx_data;
        end
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    // Counter restarts on every state change, so it measures time spent in one wait state.
    always_ff @(posedge clk) begin
        if (reset || (state_d != state)) begin
            tmo_cnt <= '0;
        end else if ((state == ACK) || (state == REL)) begin
            tmo_cnt <= tmo_cnt + 21'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || timeout_clr) begin
            timeout <= 1'b0;
        end else if (timeout_set) begin
            timeout <= 1'b1;
        end
    end
`endif

    assign busy        = (state == LOAD) || (state == REQ) || (state == ACK) || (state == REL);
    assign done        = (state == DONE);
    assign m_tr_en     = busy;
    assign m_tx_rx_req = (state == REQ) || (state == ACK);
    assign cur_idx     = idx;
    assign rb_data     = rb[rb_addr];
    assign m_comp      = 10'(COMP);
    assign m_chip_addr = cur_cmd.chip_addr;
    assign m_reg_addr  = cur_cmd.reg_addr;
    assign m_tx_data   = cur_cmd.tx_data;
    assign m_wr_rd     = cur_cmd.wr_rd;

endmodule

// File: tb/tb_i2c_cmd_seq_sv.sv
// tb/tb_i2c_cmd_seq_sv.sv - randomized self-checking bench for i2c_cmd_seq_sv (I2C_SEQ_TIMEOUT_EN optional)
module tb_i2c_cmd_seq_sv;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [23:0]   cmd_wdata = '0;
    logic [AW:0]   cmd_cnt = '0;
    logic          start = 1'b0;
    logic          busy, done;
    logic [AW-1:0] cur_idx;
    logic [AW-1:0] rb_addr = '0;
    logic [7:0]    rb_data;
    logic          m_tr_en, m_wr_rd, m_tx_rx_req;
    logic [9:0]    m_comp;
    logic [6:0]    m_chip_addr;
    logic [7:0]    m_reg_addr, m_tx_data;
    logic          m_tx_rx_req_ack = 1'b0;
    logic [7:0]    m_rx_data = '0;
`ifdef I2C_SEQ_TIMEOUT_EN
    logic          timeout;
`endif

    i2c_cmd_seq_sv #(
        .DEPTH(DEPTH),
`ifdef I2C_SEQ_TIMEOUT_EN
        .TMO_CYC(100),
`endif
        .COMP(250)
    ) dut (
`ifdef I2C_SEQ_TIMEOUT_EN
        .timeout(timeout),
`endif
        .clk(clk), .reset(reset), .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_cnt(cmd_cnt), .start(start), .busy(busy), .done(done), .cur_idx(cur_idx),
        .rb_addr(rb_addr), .rb_data(rb_data), .m_tr_en(m_tr_en), .m_comp(m_comp),
        .m_chip_addr(m_chip_addr), .m_reg_addr(m_reg_addr), .m_tx_data(m_tx_data),
        .m_wr_rd(m_wr_rd), .m_tx_rx_req(m_tx_rx_req), .m_tx_rx_req_ack(m_tx_rx_req_ack),
        .m_rx_data(m_rx_data)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [23:0] model_tbl [DEPTH];
    logic [7:0]  model_rb  [DEPTH];
    bit          model_rb_ok [DEPTH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic write_entry(input int addr, input logic [23:0] data);
        @(negedge clk);
        cmd_we    = 1'b1;
        cmd_addr  = AW'(addr);
        cmd_wdata = data;
        model_tbl[addr] = data;
        @(negedge clk);
        cmd_we = 1'b0;
    endtask

    task automatic check_rb();
        for (int k = 0; k < DEPTH; k++) begin
            if (model_rb_ok[k]) begin
                rb_addr = AW'(k);
                #1;
                chk($sformatf("rb[%0d]", k), 32'(rb_data), 32'(model_rb[k]));
            end
        end
    endtask

    // Acts as the I2C master: acks each request after a random delay and
    // checks ordering, fields, handshake latency and the final done pulse.
    task automatic run_seq(input int cnt, input bit disturb, input int rx_fixed);
        int exp_n, n_tr, cyc, dly, last_drop, phase;
        bit got_done;
        logic [23:0] obs;
        exp_n = (cnt > DEPTH) ? DEPTH : cnt;
        n_tr = 0; cyc = 0; last_drop = 0; phase = 0; got_done = 1'b0; dly = 0;
        @(negedge clk);
        cmd_cnt = (AW+1)'(cnt);
        start   = 1'b1;
        while (!got_done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start  = 1'b0;
            cmd_we = 1'b0;
            if (cyc == 1) cmd_cnt = (AW+1)'($urandom);
            obs = {m_wr_rd, m_chip_addr, m_reg_addr, m_tx_data};
            if (done) begin
                got_done = 1'b1;
                chk("txn_count", n_tr, exp_n);
                chk("done_lat", (exp_n == 0) ? cyc : cyc - last_drop, 1);
                chk("done_busy", busy, 0);
                chk("done_tr_en", m_tr_en, 0);
            end else if (phase == 0) begin
                if (m_tx_rx_req) begin
                    if (n_tr >= exp_n) begin
                        chk("extra_req", n_tr, exp_n);
                        got_done = 1'b1;
                    end else begin
                        chk("req_lat", (n_tr == 0) ? cyc : cyc - last_drop, 2);
                        chk("fields", obs, model_tbl[n_tr]);
                        chk("cur_idx", cur_idx, n_tr);
                        chk("tr_en", m_tr_en, 1);
                        if (disturb && n_tr == 0 && exp_n >= 2) begin
                            start     = 1'b1;
                            cmd_we    = 1'b1;
                            cmd_addr  = AW'(exp_n - 1);
                            cmd_wdata = ~model_tbl[exp_n - 1];
                        end
                        dly   = $urandom_range(0, 3);
                        phase = 1;
                    end
                end
            end else if (phase == 1) begin
                chk("req_hold", m_tx_rx_req, 1);
                chk("fields_hold", obs, model_tbl[n_tr]);
                if (dly == 0) begin
                    m_tx_rx_req_ack = 1'b1;
                    m_rx_data = (rx_fixed >= 0) ? 8'(rx_fixed) : 8'($urandom);
                    if (!model_tbl[n_tr][23]) begin
                        model_rb[n_tr]    = m_rx_data;
                        model_rb_ok[n_tr] = 1'b1;
                    end
                    phase = 2;
                end else begin
                    dly--;
                end
            end else if (phase == 2) begin
                chk("req_drop", m_tx_rx_req, 0);
                chk("fields_rel", obs, model_tbl[n_tr]);
                dly   = $urandom_range(0, 3);
                phase = 3;
            end else begin
                if (dly == 0) begin
                    m_tx_rx_req_ack = 1'b0;
                    last_drop = cyc;
                    n_tr++;
                    phase = 0;
                end else begin
                    dly--;
                end
            end
        end
        if (!got_done) chk("seq_timeout", 0, 1);
        m_tx_rx_req_ack = 1'b0;
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
        check_rb();
    endtask

    initial begin
        int cyc, seen, cnt;
        for (int k = 0; k < DEPTH; k++) model_rb_ok[k] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tr_en", m_tr_en, 0);
        chk("rst_req", m_tx_rx_req, 0);
        chk("rst_comp", m_comp, 250);
        chk("rst_idx", cur_idx, 0);
        chk("rst_fields", {m_wr_rd, m_chip_addr, m_reg_addr, m_tx_data}, 0);
        reset = 1'b0;

        // three writes
        write_entry(0, {1'b1, 7'h50, 8'h10, 8'hAA});
        write_entry(1, {1'b1, 7'h50, 8'h11, 8'hBB});
        write_entry(2, {1'b1, 7'h50, 8'h12, 8'hCC});
        run_seq(3, 1'b0, -1);

        // single read, then mixed write/read/write
        write_entry(0, {1'b0, 7'h68, 8'h75, 8'h00});
        run_seq(1, 1'b0, 8'h71);
        rb_addr = '0;
        #1 chk("rb0_read", rb_data, 8'h71);
        write_entry(0, {1'b1, 7'h68, 8'h6B, 8'h01});
        write_entry(1, {1'b0, 7'h68, 8'h3B, 8'h00});
        write_entry(2, {1'b1, 7'h68, 8'h1A, 8'h03});
        run_seq(3, 1'b0, -1);
        rb_addr = '0;
        #1 chk("rb0_kept", rb_data, 8'h71);

        // empty table
        run_seq(0, 1'b0, -1);

        // start and cmd_we while busy
        write_entry(3, 24'h812345);
        run_seq(4, 1'b1, -1);

        // reset while waiting for ack
        @(negedge clk);
        cmd_cnt = 5'd2;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; seen = 0;
        while (seen < 2 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (m_tx_rx_req) seen++;
        end
        chk("rst_reach_ack", seen, 2);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_req", m_tx_rx_req, 0);
        chk("abort_tr_en", m_tr_en, 0);
        chk("abort_busy", busy, 0);
        reset = 1'b0;
        run_seq(2, 1'b0, -1);

        // random tables and counts, including counts above DEPTH
        for (int it = 0; it < 8; it++) begin
            for (int k = 0; k < DEPTH; k++) write_entry(k, 24'($urandom));
            cnt = (it == 0) ? 20 : $urandom_range(0, 20);
            run_seq(cnt, it[0], -1);
        end

`ifdef I2C_SEQ_TIMEOUT_EN
        write_entry(0, {1'b1, 7'h22, 8'h01, 8'h02});
        @(negedge clk);
        cmd_cnt = 5'd1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!m_tx_rx_req && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("tmo_req_seen", m_tx_rx_req, 1);
        cyc = 0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("tmo_cycle", cyc, 101);
        chk("tmo_flag", timeout, 1);
        chk("tmo_req_low", m_tx_rx_req, 0);
        chk("tmo_tr_en", m_tr_en, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
